serial_word_comparator: RTL and testbench
=========================================

SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

Interface
REQ-001 Parameter DIGIT_W, default 1: bits per serial beat (digit), legal range 1..16.
REQ-002 Parameter WORD_BEATS, default 16: beats per compared word, legal range 2..256.
REQ-003 Parameter MSB_FIRST, default 1: 1 = most significant digit first, 0 = least significant digit first.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid  input  1  a/b carry one beat this cycle.
REQ-007 clear  input  1  synchronous abort of the word in progress.
REQ-008 a  input  DIGIT_W  digit of operand A.
REQ-009 b  input  DIGIT_W  digit of operand B.
REQ-010 busy  output  1  a word is partially received (beat count nonzero).
REQ-011 done  output  1  one-cycle pulse: a new result is valid.
REQ-012 a_less_b, a_eq_b, a_greater_b  output  1 each  registered result of the last completed word.

Function
REQ-013 Beat accepted when valid=1 and clear=0; beat counter counts 0..WORD_BEATS-1 and wraps to 0 after the final beat.
REQ-014 Running state holds eq_r (reset 1) and lt_r (reset 0) for the word in progress.
REQ-015 MSB_FIRST=1: on each accepted beat, if eq_r=1 and a!=b, lt_r <= (a<b) and eq_r <= 0; once eq_r=0, later digits are ignored.
REQ-016 MSB_FIRST=0: on each accepted beat, lt_r <= (a<b) | ((a==b) & lt_r) and eq_r <= eq_r & (a==b).
REQ-017 Digit comparison is unsigned over DIGIT_W bits, except as given in REQ-027.
REQ-018 Final beat: the result computed with that beat included is registered into the outputs, done=1 on the next cycle (latency 1), and the running state returns to eq_r=1, lt_r=0 in the same edge.
REQ-019 Exactly one of a_less_b/a_eq_b/a_greater_b is 1 after the first done; outputs hold until the next done.
REQ-020 valid=0 cycles are gaps: no state change; words may be spread over any number of cycles.
REQ-021 Back-to-back words need no idle cycle; the first beat of word N+1 may coincide with done of word N.
REQ-022 clear=1: beat counter and running state return to reset values next edge; registered outputs unchanged; no done; a beat presented with clear is discarded.
REQ-023 busy = (beat counter != 0).

Reset
REQ-024 rst_n=0 asynchronously forces beat counter=0, eq_r=1, lt_r=0, done=0, busy=0 and a_less_b=a_eq_b=a_greater_b=0.
REQ-025 Reset mid-word discards the partial word; the first accepted beat after release is beat 0.

Configuration
REQ-026 Macro SERIAL_CMP_SIGNED_EN selects signed comparison.
REQ-027 With SERIAL_CMP_SIGNED_EN defined, operands are two's complement: the top bit of both digits is inverted before comparison on the most significant beat (beat 0 if MSB_FIRST=1, beat WORD_BEATS-1 if MSB_FIRST=0).
REQ-028 Without SERIAL_CMP_SIGNED_EN, all beats compare unsigned and no sign logic is synthesised.

Structure
REQ-029 Package serial_cmp_pkg holds typedef enum cmp_result_t {CMP_LESS, CMP_EQ, CMP_GREATER} and localparam limits for DIGIT_W and WORD_BEATS.
REQ-030 Sub-module serial_cmp_digit (combinational, DIGIT_W parameter, sign-flip input) produces digit lt/eq; the top level instantiates it once.
REQ-031 Beat counter width is $clog2(WORD_BEATS); parameters outside their legal range stop elaboration with an error.

Verification
REQ-032 DIGIT_W=4, WORD_BEATS=4, MSB_FIRST=1, a=16'h1234, b=16'h1243, beats consecutive -> done one cycle after beat 3, a_less_b=1.
REQ-033 Same operands with MSB_FIRST=0, digits fed LSB first -> a_less_b=1; a=b=16'hBEEF -> a_eq_b=1.
REQ-034 DIGIT_W=1, WORD_BEATS=16, a=16'h6482, b=16'h6262 with valid gaps every other cycle -> one done only, a_greater_b=1.
REQ-035 clear asserted after beat 2, then a=b=16'h0000 fed -> prior outputs held until done, then a_eq_b=1; no spurious done.
REQ-036 SERIAL_CMP_SIGNED_EN defined, a=16'hFFFF, b=16'h0001 -> a_less_b=1; undefined -> a_greater_b=1.
REQ-037 rst_n pulsed low mid-word, then two back-to-back words -> all outputs 0 during reset; two done pulses with correct results.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and parameter limits for the serial word comparator.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      CMP_LESS,
      CMP_EQ,
      CMP_GREATER
   } cmp_result_t;

   localparam int unsigned DIGIT_W_MIN    = 1;
   localparam int unsigned DIGIT_W_MAX    = 16;
   localparam int unsigned WORD_BEATS_MIN = 2;
   localparam int unsigned WORD_BEATS_MAX = 256;

   function automatic cmp_result_t cmp_decode(input logic lt, input logic eq);
      return eq ? CMP_EQ : (lt ? CMP_LESS : CMP_GREATER);
   endfunction

endpackage

// File: rtl/serial_word_comparator_if.sv
// Beat input / result output bundle of the serial word comparator.
interface serial_word_comparator_if #(
   parameter int unsigned DIGIT_W = 1
) ();

   logic               valid;
   logic               clear;
   logic [DIGIT_W-1:0] a;
   logic [DIGIT_W-1:0] b;
   logic               busy;
   logic               done;
   logic               a_less_b;
   logic               a_eq_b;
   logic               a_greater_b;

   modport master (
      output valid, clear, a, b,
      input  busy, done, a_less_b, a_eq_b, a_greater_b
   );

   modport slave (
      input  valid, clear, a, b,
      output busy, done, a_less_b, a_eq_b, a_greater_b
   );

endinterface

// File: rtl/serial_cmp_digit.sv
// Combinational digit comparator; i_flip inverts both sign bits first.
module serial_cmp_digit
   import serial_cmp_pkg::*;
#(
   parameter int unsigned DIGIT_W = 1
) (
   input  logic [DIGIT_W-1:0] i_a,
   input  logic [DIGIT_W-1:0] i_b,
   input  logic               i_flip,
   output logic               o_lt,
   output logic               o_eq
);

   localparam logic [DIGIT_W-1:0] MSB_MASK = DIGIT_W'(1) << (DIGIT_W - 1);

   logic [DIGIT_W-1:0] w_a;
   logic [DIGIT_W-1:0] w_b;

   assign w_a  = i_a ^ (i_flip ? MSB_MASK : '0);
   assign w_b  = i_b ^ (i_flip ? MSB_MASK : '0);
   assign o_lt = (w_a < w_b);
   assign o_eq = (i_a == i_b);

endmodule

// File: rtl/serial_word_comparator.sv
// Digit-serial magnitude comparator of two words.
// Define SERIAL_CMP_SIGNED_EN for two's-complement comparison.
module serial_word_comparator
   import serial_cmp_pkg::*;
#(
   parameter int unsigned DIGIT_W    = 1,
   parameter int unsigned WORD_BEATS = 16,
   parameter int unsigned MSB_FIRST  = 1
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_word_comparator_if.slave bus
);

   if (DIGIT_W < DIGIT_W_MIN || DIGIT_W > DIGIT_W_MAX) begin : g_bad_digit_w
      $error("serial_word_comparator: DIGIT_W out of range 1..16");
   end
   if (WORD_BEATS < WORD_BEATS_MIN || WORD_BEATS > WORD_BEATS_MAX) begin : g_bad_beats
      $error("serial_word_comparator: WORD_BEATS out of range 2..256");
   end
   if (MSB_FIRST > 1) begin : g_bad_order
      $error("serial_word_comparator: MSB_FIRST must be 0 or 1");
   end

   localparam int unsigned       CNT_W = $clog2(WORD_BEATS);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_BEATS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_eq;
   logic             r_lt;
   logic             r_done;
   logic             r_less;
   logic             r_same;
   logic             r_greater;

   logic        w_flip;
   logic        w_dlt;
   logic        w_deq;
   logic        w_last;
   logic        w_eq_n;
   logic        w_lt_n;
   cmp_result_t w_res;

`ifdef SERIAL_CMP_SIGNED_EN
   localparam logic [CNT_W-1:0] SIGN_BEAT = (MSB_FIRST != 0) ? '0 : LAST;
   assign w_flip = (r_cnt == SIGN_BEAT);
`else
   assign w_flip = 1'b0;
`endif

   serial_cmp_digit #(
      .DIGIT_W (DIGIT_W)
   ) u_digit (
      .i_a    (bus.a),
      .i_b    (bus.b),
      .i_flip (w_flip),
      .o_lt   (w_dlt),
      .o_eq   (w_deq)
   );

   assign w_last = (r_cnt == LAST);

   // MSB-first: first differing digit decides; LSB-first: later digits override.
   always_comb begin
      w_eq_n = r_eq & w_deq;
      w_lt_n = r_lt;
      if (MSB_FIRST != 0) begin
         if (r_eq && !w_deq) w_lt_n = w_dlt;
      end else begin
         w_lt_n = w_dlt | (w_deq & r_lt);
      end
   end

   assign w_res = cmp_decode(w_lt_n, w_eq_n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_eq      <= 1'b1;
         r_lt      <= 1'b0;
         r_done    <= 1'b0;
         r_less    <= 1'b0;
         r_same    <= 1'b0;
         r_greater <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.clear) begin
            r_cnt <= '0;
            r_eq  <= 1'b1;
            r_lt  <= 1'b0;
         end else if (bus.valid) begin
            if (w_last) begin
               r_cnt     <= '0;
               r_eq      <= 1'b1;
               r_lt      <= 1'b0;
               r_done    <= 1'b1;
               r_less    <= (w_res == CMP_LESS);
               r_same    <= (w_res == CMP_EQ);
               r_greater <= (w_res == CMP_GREATER);
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_eq  <= w_eq_n;
               r_lt  <= w_lt_n;
            end
         end
      end
   end

   assign bus.busy        = (r_cnt != '0);
   assign bus.done        = r_done;
   assign bus.a_less_b    = r_less;
   assign bus.a_eq_b      = r_same;
   assign bus.a_greater_b = r_greater;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench: 4x4 MSB-first, 4x4 LSB-first and 1x16 MSB-first comparators.
module tb_serial_word_comparator;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_word_comparator_if #(.DIGIT_W(4)) m_if ();
   serial_word_comparator_if #(.DIGIT_W(4)) l_if ();
   serial_word_comparator_if #(.DIGIT_W(1)) b_if ();

   serial_word_comparator #(
      .DIGIT_W(4), .WORD_BEATS(4), .MSB_FIRST(1)
   ) u_msb (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));

   serial_word_comparator #(
      .DIGIT_W(4), .WORD_BEATS(4), .MSB_FIRST(0)
   ) u_lsb (.clk(clk), .rst_n(rst_n), .bus(l_if.slave));

   serial_word_comparator #(
      .DIGIT_W(1), .WORD_BEATS(16), .MSB_FIRST(1)
   ) u_bit (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

`ifdef SERIAL_CMP_SIGNED_EN
   localparam bit SIGNED = 1'b1;
`else
   localparam bit SIGNED = 1'b0;
`endif

   typedef struct {
      int          sel;
      logic [15:0] a;
      logic [15:0] b;
      bit          gaps;
      logic [2:0]  exp;
   } vec_t;

   vec_t       vecs[10];
   logic [2:0] held[3];
   int         n_tests = 0;
   int         n_fail  = 0;

   // Whole-word reference: {lt, eq, gt}
   function automatic logic [2:0] model(logic [15:0] a, logic [15:0] b);
      int va;
      int vb;
      va = SIGNED ? int'($signed(a)) : int'(a);
      vb = SIGNED ? int'($signed(b)) : int'(b);
      if (va < vb) return 3'b100;
      if (va == vb) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [4:0] outs(int sel);
      logic [4:0] r;
      r = '0;
      case (sel)
         0: r = {m_if.busy, m_if.done, m_if.a_less_b, m_if.a_eq_b, m_if.a_greater_b};
         1: r = {l_if.busy, l_if.done, l_if.a_less_b, l_if.a_eq_b, l_if.a_greater_b};
         default: r = {b_if.busy, b_if.done, b_if.a_less_b, b_if.a_eq_b, b_if.a_greater_b};
      endcase
      return r;
   endfunction

   task automatic check(string name, logic [4:0] got, logic [4:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: {busy,done,lt,eq,gt} got %b expected %b", name, got, exp);
      end
   endtask

   task automatic drive(int sel, bit v, bit c, logic [3:0] da, logic [3:0] db);
      m_if.valid = v && sel == 0;
      m_if.clear = c && sel == 0;
      m_if.a     = da;
      m_if.b     = db;
      l_if.valid = v && sel == 1;
      l_if.clear = c && sel == 1;
      l_if.a     = da;
      l_if.b     = db;
      b_if.valid = v && sel == 2;
      b_if.clear = c && sel == 2;
      b_if.a     = da[0];
      b_if.b     = db[0];
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(int sel, logic [15:0] a, logic [15:0] b,
                            bit gaps, logic [2:0] exp, string name);
      int n;
      int idx;
      n = (sel == 2) ? 16 : 4;
      for (int i = 0; i < n; i++) begin
         idx = (sel == 1) ? i : n - 1 - i;
         if (sel == 2) drive(sel, 1'b1, 1'b0, {3'b0, a[idx]}, {3'b0, b[idx]});
         else          drive(sel, 1'b1, 1'b0, a[idx*4 +: 4], b[idx*4 +: 4]);
         if (i < n - 1) begin
            check({name, " beat"}, outs(sel), {2'b10, held[sel]});
            if (gaps) begin
               drive(sel, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
               check({name, " gap"}, outs(sel), {2'b10, held[sel]});
            end
         end else begin
            held[sel] = exp;
            check({name, " done"}, outs(sel), {2'b01, exp});
         end
      end
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      int          rs;

      for (int s = 0; s < 3; s++) held[s] = 3'b000;

      vecs[0] = '{0, 16'h1234, 16'h1243, 1'b0, 3'b100};
      vecs[1] = '{1, 16'h1234, 16'h1243, 1'b0, 3'b100};
      vecs[2] = '{1, 16'hBEEF, 16'hBEEF, 1'b0, 3'b010};
      vecs[3] = '{2, 16'h6482, 16'h6262, 1'b1, 3'b001};
      vecs[4] = '{0, 16'hFFFF, 16'h0001, 1'b0, SIGNED ? 3'b100 : 3'b001};
      vecs[5] = '{1, 16'hFFFF, 16'h0001, 1'b1, SIGNED ? 3'b100 : 3'b001};
      vecs[6] = '{2, 16'hFFFF, 16'h0001, 1'b0, SIGNED ? 3'b100 : 3'b001};
      vecs[7] = '{0, 16'h8000, 16'h7FFF, 1'b1, SIGNED ? 3'b100 : 3'b001};
      vecs[8] = '{1, 16'h00F0, 16'h0F00, 1'b0, 3'b100};
      vecs[9] = '{0, 16'hABCD, 16'hABCD, 1'b0, 3'b010};

      rst_n = 1'b0;
      drive(3, 1'b0, 1'b0, 4'h0, 4'h0);
      for (int s = 0; s < 3; s++) check("reset", outs(s), 5'b00000);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         send_word(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].gaps, vecs[i].exp, "vec");

      // Abort a partial word whose digits already differ; the beat with clear is dropped
      send_word(0, 16'h1234, 16'h1243, 1'b0, 3'b100, "pre_clear");
      drive(0, 1'b1, 1'b0, 4'hF, 4'h0);
      check("clear beat0", outs(0), {2'b10, held[0]});
      drive(0, 1'b1, 1'b0, 4'hF, 4'h0);
      check("clear beat1", outs(0), {2'b10, held[0]});
      drive(0, 1'b1, 1'b1, 4'hF, 4'h0);
      check("clear hold", outs(0), {2'b00, held[0]});
      send_word(0, 16'h0000, 16'h0000, 1'b0, 3'b010, "after_clear");

      drive(1, 1'b1, 1'b0, 4'h1, 4'h0);
      drive(1, 1'b1, 1'b0, 4'h1, 4'h0);
      check("pre_reset busy", outs(1), {2'b10, held[1]});
      rst_n = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) check("async reset", outs(s), 5'b00000);
      @(posedge clk);
      #1;
      check("reset hold", outs(1), 5'b00000);
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) held[s] = 3'b000;
      send_word(1, 16'h00FF, 16'h00FE, 1'b0, model(16'h00FF, 16'h00FE), "b2b_1");
      send_word(1, 16'h1000, 16'h2000, 1'b0, model(16'h1000, 16'h2000), "b2b_2");
      send_word(2, 16'h8001, 16'h8001, 1'b0, model(16'h8001, 16'h8001), "b2b_bit");

      for (int k = 0; k < 40; k++) begin
         rs = int'($urandom_range(0, 2));
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
            default: rb = 16'($urandom);
         endcase
         send_word(rs, ra, rb, 1'($urandom_range(0, 1)), model(ra, rb), "rand");
      end

      drive(3, 1'b0, 1'b0, 4'h0, 4'h0);
      for (int s = 0; s < 3; s++) check("final idle", outs(s), {2'b00, held[s]});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
